// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard. Counts outstanding writes per
// architectural register and stalls decode while a source is not yet
// readable from the register file or a destination counter is saturated.
module rf_scoreboard #(
  parameter int unsigned CNT_W     = 2,
  parameter bit          BYPASS_EN = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_raddr,
  input  logic        i_rs1_used,
  input  logic [4:0]  i_rs2_raddr,
  input  logic        i_rs2_used,
  input  logic        i_issue,
  input  logic        i_issue_wen,
  input  logic [4:0]  i_issue_rd,
  input  logic        i_rd_wen,
  input  logic [4:0]  i_rd_waddr,
  output logic        o_stall,
  output logic        o_issue_fire,
  output logic [31:0] o_busy,
  output logic        o_idle,
  output logic        o_err
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Entry 0 is held at zero: x0 never increments or decrements.
  logic [CNT_W-1:0] count_q [32];
  logic [CNT_W-1:0] count_d [32];
  logic             err_q, err_d;

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic             rs1_haz, rs2_haz, full_haz;
  logic             inc, dec, same_reg, underflow;

  // Hazard detection and issue gating.
  always_comb begin
    cnt_rs1  = count_q[i_rs1_raddr];
    cnt_rs2  = count_q[i_rs2_raddr];
    cnt_rd   = count_q[i_issue_rd];
    cnt_wb   = count_q[i_rd_waddr];
    // Bypass only hides the hazard when this writeback retires the last pending write.
    rs1_haz  = i_rs1_used && (i_rs1_raddr != '0) && (cnt_rs1 != '0) &&
               !(BYPASS_EN && i_rd_wen && (i_rd_waddr == i_rs1_raddr) && (cnt_rs1 == CntOne));
    rs2_haz  = i_rs2_used && (i_rs2_raddr != '0) && (cnt_rs2 != '0) &&
               !(BYPASS_EN && i_rd_wen && (i_rd_waddr == i_rs2_raddr) && (cnt_rs2 == CntOne));
    // A same-cycle decrement does not relieve saturation.
    full_haz = i_issue_wen && (i_issue_rd != '0) && (cnt_rd == CntMax);
    o_stall      = i_issue && (rs1_haz || rs2_haz || full_haz);
    o_issue_fire = i_issue && !o_stall;
  end

  // Next-state counters and sticky underflow flag.
  always_comb begin
    inc       = o_issue_fire && i_issue_wen && (i_issue_rd != '0);
    dec       = i_rd_wen && (i_rd_waddr != '0) && (cnt_wb != '0);
    // Increment and writeback on one register cancel, even from a zero count.
    same_reg  = inc && i_rd_wen && (i_rd_waddr == i_issue_rd);
    underflow = i_rd_wen && (i_rd_waddr != '0) && (cnt_wb == '0) && !same_reg;
    err_d     = err_q || underflow;
    count_d[0] = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      count_d[r] = count_q[r];
      if (!same_reg) begin
        if (inc && (i_issue_rd == 5'(r))) count_d[r] = count_q[r] + CntOne;
        if (dec && (i_rd_waddr == 5'(r))) count_d[r] = count_q[r] - CntOne;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned r = 0; r < 32; r++) count_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < 32; r++) count_q[r] <= count_d[r];
      err_q <= err_d;
    end
  end

  // Status outputs derived from current counts.
  always_comb begin
    o_busy[0] = 1'b0;
    for (int unsigned r = 1; r < 32; r++) o_busy[r] = (count_q[r] != '0);
    o_idle = (o_busy == '0);
    o_err  = err_q;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: two instances (bypass off / on) share stimulus and
// are compared against an integer-count reference model.
module tb_rf_scoreboard;

  localparam int CntMax = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd, wa;
  logic       u1, u2, iss, wen, rw;

  logic        stall_w [2];
  logic        fire_w  [2];
  logic [31:0] busy_w  [2];
  logic        idle_w  [2];
  logic        err_w   [2];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: index 0 = no bypass, index 1 = bypass.
  int cnt  [2][32];
  bit merr [2];

  always #5 clk = ~clk;

  rf_scoreboard #(.CNT_W(2), .BYPASS_EN(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_raddr(rs1), .i_rs1_used(u1), .i_rs2_raddr(rs2), .i_rs2_used(u2),
    .i_issue(iss), .i_issue_wen(wen), .i_issue_rd(rd),
    .i_rd_wen(rw), .i_rd_waddr(wa),
    .o_stall(stall_w[0]), .o_issue_fire(fire_w[0]), .o_busy(busy_w[0]),
    .o_idle(idle_w[0]), .o_err(err_w[0])
  );

  rf_scoreboard #(.CNT_W(2), .BYPASS_EN(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_raddr(rs1), .i_rs1_used(u1), .i_rs2_raddr(rs2), .i_rs2_used(u2),
    .i_issue(iss), .i_issue_wen(wen), .i_issue_rd(rd),
    .i_rd_wen(rw), .i_rd_waddr(wa),
    .o_stall(stall_w[1]), .o_issue_fire(fire_w[1]), .o_busy(busy_w[1]),
    .o_idle(idle_w[1]), .o_err(err_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit m_haz(int k, bit used, logic [4:0] a);
    if (!used || a == 0 || cnt[k][a] == 0) return 1'b0;
    // With bypass, a writeback retiring the only pending write supplies the value.
    if (k == 1 && rw && wa == a && cnt[k][a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall(int k);
    bit full;
    full = wen && rd != 0 && cnt[k][rd] == CntMax;
    return iss && (m_haz(k, u1, rs1) || m_haz(k, u2, rs2) || full);
  endfunction

  function automatic logic [31:0] m_busy(int k);
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (cnt[k][r] > 0);
    return b;
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.stall%0d", tag, k), 32'(stall_w[k]), 32'(m_stall(k)));
      chk($sformatf("%s.fire%0d", tag, k), 32'(fire_w[k]), 32'(iss && !m_stall(k)));
      chk($sformatf("%s.busy%0d", tag, k), busy_w[k], m_busy(k));
      chk($sformatf("%s.idle%0d", tag, k), 32'(idle_w[k]), 32'(m_busy(k) == 0));
      chk($sformatf("%s.err%0d", tag, k), 32'(err_w[k]), 32'(merr[k]));
    end
  endtask

  task automatic model_update();
    bit fire, inc;
    for (int k = 0; k < 2; k++) begin
      fire = iss && !m_stall(k);
      inc  = fire && wen && rd != 0;
      if (!(inc && rw && wa == rd)) begin
        if (inc) cnt[k][rd]++;
        if (rw && wa != 0) begin
          if (cnt[k][wa] > 0) cnt[k][wa]--;
          else merr[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input string tag, input bit i_iss, input bit i_wen, input logic [4:0] i_rd,
                       input bit i_u1, input logic [4:0] i_a1, input bit i_u2,
                       input logic [4:0] i_a2, input bit i_rw, input logic [4:0] i_wa);
    iss = i_iss; wen = i_wen; rd = i_rd; u1 = i_u1; rs1 = i_a1; u2 = i_u2; rs2 = i_a2;
    rw = i_rw; wa = i_wa;
    #1;
    check_all(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    // Reset must win over a simultaneous issue and writeback.
    rst = 1'b1; iss = 1'b1; wen = 1'b1; rd = 5'd3; rw = 1'b1; wa = 5'd4;
    u1 = 1'b0; u2 = 1'b0; rs1 = '0; rs2 = '0;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) cnt[k][r] = 0;
      merr[k] = 1'b0;
    end
    #1;
    rst = 1'b0; iss = 1'b0; wen = 1'b0; rw = 1'b0;
    #1;
    check_all("reset");
    chk("reset.idle_const", 32'(idle_w[0]), 32'd1);
  endtask

  initial begin
    logic [4:0] pick;
    rst = 1'b0; iss = 0; wen = 0; rd = 0; u1 = 0; u2 = 0; rs1 = 0; rs2 = 0; rw = 0; wa = 0;
    @(posedge clk); #1;
    do_reset();

    // Issue to x5, then a reader of x5 stalls.
    drive("iss5", 1, 1, 5'd5, 0, 0, 0, 0, 0, 0);
    chk("iss5.busy_bit", 32'(busy_w[0][5]), 32'd1);
    drive("rd5_stall", 1, 0, 0, 1, 5'd5, 0, 0, 0, 0);
    // Writeback to x5 in the reading cycle: bypass decides.
    iss = 1; u1 = 1; rs1 = 5'd5; rw = 1; wa = 5'd5; wen = 0; #1;
    chk("wb5.stall_nobyp", 32'(stall_w[0]), 32'd1);
    chk("wb5.stall_byp", 32'(stall_w[1]), 32'd0);
    drive("wb5", 1, 0, 0, 1, 5'd5, 0, 0, 1, 5'd5);
    drive("after_wb5", 1, 0, 0, 1, 5'd5, 0, 0, 0, 0);
    chk("after_wb5.idle", 32'(idle_w[0]), 32'd1);

    // Saturate x7, writeback in the same cycle does not relieve it.
    repeat (3) drive("iss7", 1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
    drive("full7_wb", 1, 1, 5'd7, 0, 0, 0, 0, 1, 5'd7);
    drive("iss7_fire", 1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
    repeat (3) drive("drain7", 0, 0, 0, 0, 0, 0, 0, 1, 5'd7);

    // Simultaneous issue and writeback to x9 keep the count.
    repeat (2) drive("iss9", 1, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    drive("iss_wb9", 1, 1, 5'd9, 0, 0, 0, 0, 1, 5'd9);
    chk("iss_wb9.busy_bit", 32'(busy_w[0][9]), 32'd1);
    repeat (2) drive("drain9", 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);

    // x0 is never tracked.
    drive("x0", 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 5'd0);
    drive("x0_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Underflow on x12 is sticky until reset.
    drive("uf12", 0, 0, 0, 0, 0, 0, 0, 1, 5'd12);
    chk("uf12.err", 32'(err_w[0]), 32'd1);
    drive("uf12_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        do_reset();
      end else begin
        pick = 5'($urandom_range(0, 7));
        for (int t = 0; t < 8 && cnt[0][pick] == 0 && $urandom_range(0, 19) != 0; t++)
          pick = 5'($urandom_range(1, 7));
        drive("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), pick);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
